mem_cont_rr: RTL

Parametrised successor to the single-issue memory controller. It arbitrates LOAD_COUNT load ports onto one read port and STORE_COUNT store ports onto one write port of a dual-port BRAM, with selectable fixed-priority or round-robin grant. It supports a configurable read latency by tracking tags in a pipeline. It also tracks pending stores with a saturating counter that drives the elastic "memory empty" handshake to the end-of-kernel join.

---
 rtl/mem_cont_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/mem_cont_rr.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/mem_cont_pkg.sv
// Shared helpers for the mem_cont_rr controller: sizing, one-hot decode and
// round-robin priority masking.
package mem_cont_pkg;

    // Widest arbiter supported by the one-hot decoder.
    localparam int MAX_PORTS = 32;

    // Ceiling log2, usable in parameter expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

    // Index of the set bit of a one-hot vector (0 when empty).
    function automatic int unsigned onehot_to_idx(input logic [MAX_PORTS-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            if (oh[i]) idx = idx | unsigned'(i);
        end
        return idx;
    endfunction

    // Round-robin mask bit: port idx lies strictly after the last grant.
    function automatic logic rr_above(input int unsigned idx, input int unsigned last);
        return (idx > last);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Single-grant arbiter: round-robin starting after the last grant, or fixed
// priority (lowest index) when RR_EN is 0. Grant is combinational from req.
module rr_arbiter
    import mem_cont_pkg::*;
#(
    parameter int N     = 2,
    parameter bit RR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int IDX_W = (N > 1) ? clog2(N) : 1;

    logic [IDX_W-1:0]     r_last;
    logic [N-1:0]         w_masked;
    logic [N-1:0]         w_src;
    logic [MAX_PORTS-1:0] w_grant_ext;

    // Prefer requests above the last grant; fall back to the full set so the
    // search wraps. Isolating the lowest set bit gives the one-hot grant.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_masked[i] = req[i] & rr_above(unsigned'(i), 32'(r_last));
        end
        w_src       = (RR_EN && (|w_masked)) ? w_masked : req;
        grant       = w_src & (~w_src + N'(1));
        w_grant_ext = '0;
        w_grant_ext[N-1:0] = grant;
    end

    // Pointer remembers the last granted index; it only moves on a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= '0;
        end else if (advance && (|grant)) begin
            r_last <= IDX_W'(onehot_to_idx(w_grant_ext));
        end
    end

endmodule

// File: rtl/mem_cont_rr.sv
// Multi-port BRAM controller: arbitrates load ports onto the read port and
// store ports onto the write port, tracks read tags over READ_LATENCY cycles
// and counts pending stores to drive the memory-empty handshake.
module mem_cont_rr
    import mem_cont_pkg::*;
#(
    parameter int DATA_SIZE      = 32,
    parameter int ADDRESS_SIZE   = 32,
    parameter int BB_COUNT       = 1,
    parameter int LOAD_COUNT     = 2,
    parameter int STORE_COUNT    = 2,
    parameter int READ_LATENCY   = 1,
    parameter int ST_COUNT_WIDTH = 5,
    parameter bit RR_EN          = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    output logic                                io_loadEnable,
    output logic [ADDRESS_SIZE-1:0]             io_loadAddrOut,
    input  logic [DATA_SIZE-1:0]                io_loadDataIn,
    output logic                                io_storeEnable,
    output logic [ADDRESS_SIZE-1:0]             io_storeAddrOut,
    output logic [DATA_SIZE-1:0]                io_storeDataOut,
    input  logic [BB_COUNT-1:0]                 io_bbpValids,
    input  logic [BB_COUNT*ST_COUNT_WIDTH-1:0]  io_bb_stCountArray,
    output logic [BB_COUNT-1:0]                 io_bbReadyToPrevs,
    output logic                                io_Empty_Valid,
    input  logic                                io_Empty_Ready,
    input  logic [LOAD_COUNT-1:0]               io_rdPortsPrev_valid,
    input  logic [LOAD_COUNT*ADDRESS_SIZE-1:0]  io_rdPortsPrev_bits,
    output logic [LOAD_COUNT-1:0]               io_rdPortsPrev_ready,
    output logic [LOAD_COUNT-1:0]               io_rdPortsNext_valid,
    output logic [LOAD_COUNT*DATA_SIZE-1:0]     io_rdPortsNext_bits,
    input  logic [LOAD_COUNT-1:0]               io_rdPortsNext_ready,
    input  logic [STORE_COUNT-1:0]              io_wrAddrPorts_valid,
    input  logic [STORE_COUNT*ADDRESS_SIZE-1:0] io_wrAddrPorts_bits,
    output logic [STORE_COUNT-1:0]              io_wrAddrPorts_ready,
    input  logic [STORE_COUNT-1:0]              io_wrDataPorts_valid,
    input  logic [STORE_COUNT*DATA_SIZE-1:0]    io_wrDataPorts_bits,
    output logic [STORE_COUNT-1:0]              io_wrDataPorts_ready,
    output logic                                err_underflow
);

    localparam int SUM_W   = ST_COUNT_WIDTH + clog2(BB_COUNT) + 1;
    localparam int CALC_W  = SUM_W + 2;
    localparam int CNT_MAX = (1 << ST_COUNT_WIDTH) - 1;

    // Clamp the signed next-count into the counter's unsigned range.
    function automatic logic [ST_COUNT_WIDTH-1:0] sat_cnt(input logic signed [CALC_W-1:0] v);
        if (v[CALC_W-1]) begin
            return '0;
        end else if (v > $signed(CALC_W'(CNT_MAX))) begin
            return '1;
        end else begin
            return v[ST_COUNT_WIDTH-1:0];
        end
    endfunction

    logic [LOAD_COUNT-1:0]      r_tag_p [READ_LATENCY];
    logic [LOAD_COUNT-1:0]      r_ld_vld;
    logic [DATA_SIZE-1:0]       r_ld_data [LOAD_COUNT];
    logic [ST_COUNT_WIDTH-1:0]  r_pend_cnt;
    logic                       r_err;

    logic [LOAD_COUNT-1:0]      w_inflight;
    logic [LOAD_COUNT-1:0]      w_tag_exit;
    logic [LOAD_COUNT-1:0]      w_ld_req;
    logic [LOAD_COUNT-1:0]      w_ld_grant;
    logic [STORE_COUNT-1:0]     w_st_req;
    logic [STORE_COUNT-1:0]     w_st_grant;
    logic [SUM_W-1:0]           w_add_sum;
    logic signed [CALC_W-1:0]   w_cnt_raw;
    logic                       w_unused;

    assign w_unused = io_Empty_Ready;

    // Load side: a port may issue only when nothing of its own is in flight
    // or waiting in its output register.
    always_comb begin
        w_inflight = '0;
        for (int s = 0; s < READ_LATENCY; s++) begin
            w_inflight = w_inflight | r_tag_p[s];
        end
        w_tag_exit = r_tag_p[READ_LATENCY-1];
        w_ld_req   = io_rdPortsPrev_valid & ~w_inflight & ~r_ld_vld;
        w_st_req   = io_wrAddrPorts_valid & io_wrDataPorts_valid;
    end

    rr_arbiter #(
        .N     (LOAD_COUNT),
        .RR_EN (RR_EN)
    ) u_ld_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_ld_req),
        .advance (|w_ld_req),
        .grant   (w_ld_grant)
    );

    rr_arbiter #(
        .N     (STORE_COUNT),
        .RR_EN (RR_EN)
    ) u_st_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (w_st_req),
        .advance (|w_st_req),
        .grant   (w_st_grant)
    );

    // Read/write port muxes and combinational address-side handshakes.
    always_comb begin
        io_loadEnable        = |w_ld_grant;
        io_loadAddrOut       = '0;
        io_rdPortsPrev_ready = w_ld_grant;
        for (int i = 0; i < LOAD_COUNT; i++) begin
            if (w_ld_grant[i]) io_loadAddrOut = io_rdPortsPrev_bits[i*ADDRESS_SIZE +: ADDRESS_SIZE];
        end
        io_storeEnable       = |w_st_grant;
        io_storeAddrOut      = '0;
        io_storeDataOut      = '0;
        io_wrAddrPorts_ready = w_st_grant;
        io_wrDataPorts_ready = w_st_grant;
        for (int j = 0; j < STORE_COUNT; j++) begin
            if (w_st_grant[j]) begin
                io_storeAddrOut = io_wrAddrPorts_bits[j*ADDRESS_SIZE +: ADDRESS_SIZE];
                io_storeDataOut = io_wrDataPorts_bits[j*DATA_SIZE +: DATA_SIZE];
            end
        end
    end

    // Stage p0 takes the new grant; later stages delay it to the data return.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < READ_LATENCY; s++) r_tag_p[s] <= '0;
        end else begin
            r_tag_p[0] <= w_ld_grant;
            for (int s = 1; s < READ_LATENCY; s++) r_tag_p[s] <= r_tag_p[s-1];
        end
    end

    // Output valid: set when the tag returns, cleared on consumer accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ld_vld <= '0;
        end else begin
            for (int i = 0; i < LOAD_COUNT; i++) begin
                if (w_tag_exit[i]) r_ld_vld[i] <= 1'b1;
                else if (r_ld_vld[i] && io_rdPortsNext_ready[i]) r_ld_vld[i] <= 1'b0;
            end
        end
    end

    // Returned read data lands in the owning port's register.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LOAD_COUNT; i++) begin
            if (w_tag_exit[i]) r_ld_data[i] <= io_loadDataIn;
        end
    end

    // Load data outputs and fixed handshakes.
    always_comb begin
        io_rdPortsNext_valid = r_ld_vld;
        io_rdPortsNext_bits  = '0;
        for (int i = 0; i < LOAD_COUNT; i++) begin
            io_rdPortsNext_bits[i*DATA_SIZE +: DATA_SIZE] = r_ld_data[i];
        end
        io_bbReadyToPrevs = '1;
        io_Empty_Valid    = (r_pend_cnt == '0) && !(|io_bbpValids);
        err_underflow     = r_err;
    end

    // Pending-store arithmetic: announced stores in, issued store out.
    always_comb begin
        w_add_sum = '0;
        for (int b = 0; b < BB_COUNT; b++) begin
            if (io_bbpValids[b]) begin
                w_add_sum = w_add_sum + SUM_W'(io_bb_stCountArray[b*ST_COUNT_WIDTH +: ST_COUNT_WIDTH]);
            end
        end
        w_cnt_raw = $signed(CALC_W'(r_pend_cnt)) + $signed(CALC_W'(w_add_sum))
                  - $signed(CALC_W'(io_storeEnable));
    end

    // Saturating pending counter; a negative result is a sticky underflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_pend_cnt <= sat_cnt(w_cnt_raw);
            if (w_cnt_raw[CALC_W-1]) r_err <= 1'b1;
        end
    end

endmodule
